// File: rtl/shift_issue_stage_if.sv
// Request/issue bundle between the upstream producer, shift_issue_stage and the shifter.
// master = producer/consumer side, slave = the issue stage itself.
interface shift_issue_stage_if #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH),
  parameter int DEPTH = 2
);
  localparam int OCW = $clog2(DEPTH + 2);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  logic [SHW-1:0]   req_amt;
  logic [1:0]       req_op;

  logic             shf_valid;
  logic             shf_ready;
  logic [WIDTH-1:0] shf_in;
  logic [SHW-1:0]   shf_amt;
  logic             shf_rev;
  logic             shf_sign;

  logic             op_err;
  logic [OCW-1:0]   occupancy;

  modport master (
    output req_valid, req_data, req_amt, req_op, shf_ready,
    input  req_ready, shf_valid, shf_in, shf_amt, shf_rev, shf_sign, op_err, occupancy
  );

  modport slave (
    input  req_valid, req_data, req_amt, req_op, shf_ready,
    output req_ready, shf_valid, shf_in, shf_amt, shf_rev, shf_sign, op_err, occupancy
  );
endinterface

// File: rtl/shift_issue_stage.sv
// Issue stage for the left-logical barrel shifter: decodes SLL/SRL/SRA into left-shift form.
// Optional SHIFT_ISSUE_STATS_EN adds accept and stall counters.

// Generic circular FIFO, pointers wrap modulo DEPTH.
// Latency: push visible at head the cycle after the write edge.
// Backpressure: full/empty flags only; caller must not push when full or pop when empty.
module shift_issue_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [W-1:0]               pop_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr];
  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
endmodule

// Converts shift requests to left-shift form and presents them from an output register.
// Latency: 1 cycle accept-to-issue when empty; one request per cycle sustained.
// Backpressure: req_ready = FIFO not full, registered only (no path from shf_ready).
module shift_issue_stage #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH),
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_issue_stage_if.slave   bus
`ifdef SHIFT_ISSUE_STATS_EN
  ,
  output logic [31:0]          stat_accepts,
  output logic [31:0]          stat_stalls
`endif
);
  localparam int OCW = $clog2(DEPTH + 2);
  localparam int CW  = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   amt;
    logic             rev;
    logic             sign;
  } entry_t;

  localparam int EW = $bits(entry_t);

  function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
    return r;
  endfunction

  entry_t        dec;
  entry_t        head;
  entry_t        out_q;
  logic          out_vld;
  logic          op_err_q;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_cnt;
  logic          accept;
  logic          issue;
  logic          load;
  logic          push;
  logic          pop;
  logic          bypass;

  assign accept = bus.req_valid && !fifo_full;
  assign issue  = out_vld && bus.shf_ready;
  assign load   = !out_vld || issue;
  assign pop    = load && !fifo_empty;
  // Bypass only when nothing is queued, so ordering stays strict FIFO.
  assign bypass = accept && load && fifo_empty;
  assign push   = accept && !bypass;

  always_comb begin
    dec.data = bus.req_data;
    dec.amt  = bus.req_amt;
    dec.rev  = 1'b0;
    dec.sign = 1'b0;
    case (bus.req_op)
      2'b01: begin
        dec.data = bitrev(bus.req_data);
        dec.rev  = 1'b1;
      end
      2'b10: begin
        dec.data = bitrev(bus.req_data);
        dec.rev  = 1'b1;
        dec.sign = bus.req_data[WIDTH-1];
      end
      default: ;
    endcase
  end

  shift_issue_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (dec),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_q    <= '0;
      op_err_q <= 1'b0;
    end else begin
      if (load) begin
        if (!fifo_empty) begin
          out_vld <= 1'b1;
          out_q   <= head;
        end else if (accept) begin
          out_vld <= 1'b1;
          out_q   <= dec;
        end else begin
          out_vld <= 1'b0;
        end
      end
      op_err_q <= accept && (bus.req_op == 2'b11);
    end
  end

  assign bus.req_ready = !fifo_full;
  assign bus.shf_valid = out_vld;
  assign bus.shf_in    = out_q.data;
  assign bus.shf_amt   = out_q.amt;
  assign bus.shf_rev   = out_q.rev;
  assign bus.shf_sign  = out_q.sign;
  assign bus.op_err    = op_err_q;
  assign bus.occupancy = OCW'(fifo_cnt) + OCW'(out_vld);

`ifdef SHIFT_ISSUE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_accepts <= '0;
      stat_stalls  <= '0;
    end else begin
      if (accept)              stat_accepts <= stat_accepts + 1'b1;
      if (out_vld && !bus.shf_ready) stat_stalls <= stat_stalls + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_shift_issue_stage.sv
// Randomized scoreboard bench for shift_issue_stage (default DEPTH=2, WIDTH=64).
module tb_shift_issue_stage;
  localparam int WIDTH = 64;
  localparam int SHW   = 6;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_issue_stage_if #(.WIDTH(WIDTH), .SHW(SHW), .DEPTH(DEPTH)) bus ();

`ifdef SHIFT_ISSUE_STATS_EN
  logic [31:0] stat_accepts;
  logic [31:0] stat_stalls;
`endif

  shift_issue_stage #(.WIDTH(WIDTH), .SHW(SHW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SHIFT_ISSUE_STATS_EN
    ,
    .stat_accepts (stat_accepts),
    .stat_stalls  (stat_stalls)
`endif
  );

  typedef struct {
    logic [63:0] d;
    logic [5:0]  a;
    logic        rev;
    logic        sign;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   failed = 0;
  int   occ = 0;
  logic exp_err = 1'b0;
  int   rdy_mode = 0;
  logic rdy_hold = 1'b1;
  int   accepts_seen = 0;
  int   stalls_seen = 0;
  logic stall = 1'b0;
  logic [63:0] hold_in;
  logic [5:0]  hold_amt;
  logic        hold_rev;
  logic        hold_sign;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a right shift by n equals a left shift by n of the mirrored word.
  function automatic exp_t model(input logic [63:0] d, input logic [5:0] a, input logic [1:0] op);
    exp_t m;
    m.a = a;
    m.d = d;
    m.rev = 1'b0;
    m.sign = 1'b0;
    if (op == 2'd1 || op == 2'd2) begin
      for (int i = 0; i < 64; i++) m.d[i] = d[63 - i];
      m.rev = 1'b1;
      m.sign = (op == 2'd2) ? d[63] : 1'b0;
    end
    return m;
  endfunction

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       bus.shf_ready = rdy_hold;
      1:       bus.shf_ready = ~bus.shf_ready;
      default: bus.shf_ready = ($urandom_range(0, 1) == 1);
    endcase
  end

  // Stimulus side of the scoreboard: record the expected issue for every accept.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      accepts_seen = 0;
      stalls_seen = 0;
    end else begin
      if (bus.req_valid && bus.req_ready) begin
        exp_q.push_back(model(bus.req_data, bus.req_amt, bus.req_op));
        accepts_seen++;
      end
      if (bus.shf_valid && !bus.shf_ready) stalls_seen++;
    end
  end

  // Monitor: occupancy/flag model, output stability, in-order issue comparison.
  always @(negedge clk) begin
    logic acc;
    logic iss;
    exp_t e;
    if (rst) begin
      occ = 0;
      exp_err = 1'b0;
      stall = 1'b0;
    end else begin
      chk("occupancy", 64'(bus.occupancy), 64'(occ));
      chk("shf_valid", 64'(bus.shf_valid), 64'(occ > 0));
      chk("req_ready", 64'(bus.req_ready), 64'(occ <= DEPTH));
      chk("op_err", 64'(bus.op_err), 64'(exp_err));
      if (stall) begin
        chk("stall_valid", 64'(bus.shf_valid), 64'd1);
        chk("stall_in", bus.shf_in, hold_in);
        chk("stall_amt", 64'(bus.shf_amt), 64'(hold_amt));
        chk("stall_side", 64'({bus.shf_rev, bus.shf_sign}), 64'({hold_rev, hold_sign}));
      end
      acc = bus.req_valid && bus.req_ready;
      iss = bus.shf_valid && bus.shf_ready;
      if (iss) begin
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_issue: got %0h expected none at %0t", bus.shf_in, $time);
        end else begin
          e = exp_q.pop_front();
          chk("shf_in", bus.shf_in, e.d);
          chk("shf_amt", 64'(bus.shf_amt), 64'(e.a));
          chk("shf_rev", 64'(bus.shf_rev), 64'(e.rev));
          chk("shf_sign", 64'(bus.shf_sign), 64'(e.sign));
        end
      end
      exp_err = acc && (bus.req_op == 2'b11);
      occ = occ + int'(acc) - int'(iss);
      stall = bus.shf_valid && !bus.shf_ready;
      hold_in = bus.shf_in;
      hold_amt = bus.shf_amt;
      hold_rev = bus.shf_rev;
      hold_sign = bus.shf_sign;
    end
  end

  task automatic send(input logic [63:0] d, input logic [5:0] a, input logic [1:0] op);
    int  n = 0;
    bit  done = 0;
    bus.req_valid = 1'b1;
    bus.req_data = d;
    bus.req_amt = a;
    bus.req_op = op;
    while (!done) begin
      @(negedge clk);
      done = bus.req_ready;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 100) begin
        tests++;
        failed++;
        $display("FAIL send_timeout: got no accept expected accept within 100 cycles");
        done = 1;
      end
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_outputs_check(input string tag);
    chk({tag, "_valid"}, 64'(bus.shf_valid), 64'd0);
    chk({tag, "_in"}, bus.shf_in, 64'd0);
    chk({tag, "_amt"}, 64'(bus.shf_amt), 64'd0);
    chk({tag, "_side"}, 64'({bus.shf_rev, bus.shf_sign, bus.op_err}), 64'd0);
    chk({tag, "_occ"}, 64'(bus.occupancy), 64'd0);
  endtask

  initial begin
    int n;
    bus.req_valid = 1'b0;
    bus.req_data = '0;
    bus.req_amt = '0;
    bus.req_op = 2'b00;
    bus.shf_ready = 1'b0;

    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    #1;
    reset_outputs_check("reset");
    chk("reset_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;

    // Basic conversions with the consumer always ready.
    send(64'h1, 6'd4, 2'b00);
    send(64'h8000_0000_0000_0000, 6'd3, 2'b10);
    send(64'h8000_0000_0000_0000, 6'd3, 2'b01);
    send(64'h0123_4567_89ab_cdef, 6'd0, 2'b10);
    idle(3);

    // Fill to capacity with the consumer stalled.
    rdy_hold = 1'b0;
    idle(2);
    for (int i = 0; i < 3; i++) send({$urandom, $urandom}, 6'($urandom), 2'($urandom_range(0, 2)));
    bus.req_valid = 1'b1;
    bus.req_data = 64'hdead_beef_0000_0004;
    bus.req_amt = 6'd63;
    bus.req_op = 2'b01;
    @(negedge clk);
    chk("full_req_ready", 64'(bus.req_ready), 64'd0);
    chk("full_occupancy", 64'(bus.occupancy), 64'd3);
    @(posedge clk);
    #1;
    rdy_hold = 1'b1;
    send(64'hdead_beef_0000_0004, 6'd63, 2'b01);
    idle(4);

    // Reserved opcode is issued as SLL with a one-cycle op_err.
    send(64'hFF, 6'd5, 2'b11);
    idle(3);

    // Stream with shf_ready toggling every cycle.
    rdy_mode = 1;
    for (int i = 0; i < 16; i++) send({$urandom, $urandom}, 6'($urandom), 2'($urandom_range(0, 3)));

    // Random ready and random request gaps.
    rdy_mode = 2;
    for (int i = 0; i < 150; i++) begin
      send({$urandom, $urandom}, 6'($urandom), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    rdy_mode = 0;
    rdy_hold = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      idle(1);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);

`ifdef SHIFT_ISSUE_STATS_EN
    @(negedge clk);
    chk("stat_accepts", 64'(stat_accepts), 64'(accepts_seen));
    chk("stat_stalls", 64'(stat_stalls), 64'(stalls_seen));
    @(posedge clk);
    #1;
`endif

    // Reset with three requests held.
    rdy_hold = 1'b0;
    idle(2);
    for (int i = 0; i < 3; i++) send({$urandom, $urandom}, 6'($urandom), 2'($urandom_range(0, 2)));
    #2 rst = 1'b1;
    #1;
    reset_outputs_check("midrst");
    rdy_hold = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(bus.req_ready), 64'd1);
    idle(6);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/shift_issue_stage.md
# shift_issue_stage

Upstream issue stage for the 64-bit left-logical barrel shifter. It accepts shift requests (SLL/SRL/SRA) over a valid/ready handshake and buffers them in a small FIFO. It converts each request into left-shift form (bit-reversing the operand for right shifts) and presents one registered operand/amount pair per cycle to the shifter inputs. The sideband bits `shf_rev` and `shf_sign` let the result stage restore right-shift order and arithmetic fill.

## Interface
- `WIDTH`, 64, operand width; must be a power of two.
- `SHW`, $clog2(WIDTH), shift-amount width (6 at default).
- `DEPTH`, 2, FIFO entries behind the output register; legal range 1–8.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: stage can accept a request this cycle.
- `req_data` in WIDTH: operand.
- `req_amt` in SHW: shift amount.
- `req_op` in 2: 00 SLL, 01 SRL, 10 SRA, 11 reserved.
- `shf_valid` out 1: `shf_*` outputs hold a valid issued request.
- `shf_ready` in 1: downstream consumes the issued request.
- `shf_in` out WIDTH: operand in left-shift form; drives the shifter `in`.
- `shf_amt` out SHW: drives the shifter `shift_amount`.
- `shf_rev` out 1: result must be bit-reversed (SRL/SRA).
- `shf_sign` out 1: original `req_data[WIDTH-1]` for SRA, else 0.
- `op_err` out 1: one-cycle pulse when a reserved opcode is accepted.
- `occupancy` out $clog2(DEPTH+2): held requests (FIFO plus output register).

## Operation
- Accept occurs when `req_valid && req_ready`. Issue occurs when `shf_valid && shf_ready`.
- Decode happens at accept; the stored entry is the converted form.
  - SLL: `shf_in` = data, `rev`=0, `sign`=0.
  - SRL: `shf_in` = bitreverse(data), `rev`=1, `sign`=0.
  - SRA: `shf_in` = bitreverse(data), `rev`=1, `sign`=data[WIDTH-1].
  - Reserved (11): decoded as SLL, and `op_err` pulses on the cycle after the accept edge.
- Amount is passed unchanged; no saturation. An amount of 0 yields the unshifted operand.
- The output register loads when it is empty or issuing in the same cycle.
  - Source is the FIFO head if the FIFO is non-empty.
  - Otherwise the source is the incoming request (bypass).
- A request entering while the output register is occupied and not issuing goes to the FIFO tail.
- Ordering is strict FIFO; the bypass path is never taken while the FIFO holds entries.
- `req_ready` = !(FIFO full). It is registered-independent: no combinational path from `shf_ready`.
- Simultaneous accept and issue with FIFO full: `req_ready` is 0, so no accept occurs. The issue proceeds and `req_ready` rises the following cycle.
- Simultaneous accept and issue with FIFO empty and output register valid: the new request loads the output register directly; occupancy is unchanged.
- FIFO pointers wrap modulo DEPTH.
- Reset values:
  - `shf_valid`=0, `shf_in`=0, `shf_amt`=0, `shf_rev`=0, `shf_sign`=0.
  - `op_err`=0, `occupancy`=0, `req_ready`=1 (after reset deassertion).
  - FIFO pointers are 0.
- Reset mid-operation discards all held requests, including the output register contents.

## Timing
- Latency: a request accepted at edge N is visible on `shf_*` after edge N if the stage was empty (1 cycle).
- Throughput: one request per cycle when `shf_ready` is held high.
- Outputs are held stable while `shf_valid && !shf_ready`.
- `shf_valid` never drops without an issue.
- Capacity: DEPTH+1 requests. With `shf_ready`=0, `req_ready` falls after DEPTH+1 accepts.
- `occupancy` updates on the same edge as the accept/issue that changes it.

## Configuration
- `SHIFT_ISSUE_STATS_EN` defined: adds outputs `stat_accepts` (32 bit, counts accepts) and `stat_stalls` (32 bit, counts cycles with `shf_valid && !shf_ready`).
  - Both counters wrap at 2^32 and reset to 0 on `rst`.
- Not defined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset, then SLL data=0x1, amt=4, `shf_ready`=1 → next cycle `shf_valid`=1, `shf_in`=0x1, `shf_amt`=4, `rev`=0, `sign`=0, `occupancy`=1.
- SRA data=0x8000_0000_0000_0000, amt=3 → `shf_in`=0x0000_0000_0000_0001, `rev`=1, `sign`=1. SRL of the same data → `sign`=0.
- Hold `shf_ready`=0 and drive 4 back-to-back requests (DEPTH=2) → 3 accepted, `req_ready`=0 after the third, `occupancy`=3. Release → issued in accept order, one per cycle.
- Continuous stream of 16 requests with `shf_ready` toggling every cycle → no loss, no duplication, order preserved, outputs stable during stalls.
- `req_op`=11 with data=0xFF → issued as SLL, `op_err` pulses exactly one cycle.
- Assert `rst` with 3 requests held → all outputs return to reset values immediately; no held request issues after reset release.
